// File: rtl/route_chk_pkg.sv
// route_chk_pkg: shared FSM state encoding, PRBS tap table and parameter limits
// for the routed-loop PRBS checker.
package route_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam int LOOP_LAT_MIN = 1;
    localparam int LOOP_LAT_MAX = 16;
    localparam int LFSR_W_MAX   = 31;

    // Right-shifting Fibonacci form: x^n + x^k + 1 feeds back state bits 0 and n-k.
    function automatic logic [LFSR_W_MAX-1:0] lfsr_taps(input int width);
        logic [LFSR_W_MAX-1:0] taps;
        case (width)
            7:       taps = 31'h0000_0003;
            9:       taps = 31'h0000_0011;
            15:      taps = 31'h0000_0003;
            23:      taps = 31'h0000_0021;
            31:      taps = 31'h0000_0009;
            default: taps = '0;
        endcase
        return taps;
    endfunction

    function automatic bit lfsr_w_legal(input int width);
        return lfsr_taps(width) != '0;
    endfunction

endpackage

// File: rtl/route_chk_lfsr.sv
// route_chk_lfsr: Fibonacci PRBS generator with all-ones reload and advance enable.
// Output bit is state bit 0; the register can never reach all-zero from the seed.
module route_chk_lfsr
    import route_chk_pkg::*;
#(
    parameter int LFSR_W = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic out_bit
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = '1;
        end else if (en) begin
            lfsr_d = {^(lfsr_q & TAPS), lfsr_q[LFSR_W-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= '1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out_bit = lfsr_q[0];

endmodule

// File: rtl/route_prbs_checker.sv
// route_prbs_checker: drives a PRBS bit onto a routed arc, checks the looped-back bit
// and counts mismatches. Define ROUTE_CHK_FIRST_ERR_EN to add the FIRST_ERR_IDX output.
module route_prbs_checker
    import route_chk_pkg::*;
#(
    parameter int LFSR_W     = 7,
    parameter int LOOP_LAT   = 1,
    parameter int RUN_CYCLES = 1024,
    parameter int ERR_W      = 16
) (
    input  logic             CLK,
    input  logic             LSR,
    input  logic             START,
    output logic             TX,
    input  logic             RX,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT
`ifdef ROUTE_CHK_FIRST_ERR_EN
    ,
    output logic [((RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1)-1:0] FIRST_ERR_IDX
`endif
);

    localparam int CNT_W = $clog2(RUN_CYCLES + LOOP_LAT_MAX + 1);
    localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(LOOP_LAT - 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_CYCLES - 1);

    if (!lfsr_w_legal(LFSR_W) || LOOP_LAT < LOOP_LAT_MIN || LOOP_LAT > LOOP_LAT_MAX
        || RUN_CYCLES < 1) begin : g_bad_params
        $error("route_prbs_checker: illegal LFSR_W, LOOP_LAT or RUN_CYCLES");
    end

    state_e              state_q;
    state_e              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [LOOP_LAT-1:0] dly_q;
    logic [LOOP_LAT-1:0] dly_d;
    logic                tx_q;
    logic                tx_d;
    logic [ERR_W-1:0]    err_q;
    logic [ERR_W-1:0]    err_d;
    logic                start_acc;
    logic                active;
    logic                prime_end;
    logic                run_end;
    logic                mismatch;
    logic                lfsr_bit;

    assign start_acc = START && (state_q == ST_IDLE || state_q == ST_DONE);
    assign active    = (state_q == ST_PRIME) || (state_q == ST_RUN);
    assign prime_end = (state_q == ST_PRIME) && (cnt_q == PRIME_LAST);
    assign run_end   = (state_q == ST_RUN) && (cnt_q == RUN_LAST);
    assign mismatch  = (state_q == ST_RUN) && (RX != dly_q[LOOP_LAT-1]);

    route_chk_lfsr #(
        .LFSR_W (LFSR_W)
    ) u_lfsr (
        .clk     (CLK),
        .rst     (LSR),
        .load    (start_acc),
        .en      (active),
        .out_bit (lfsr_bit)
    );

    always_ff @(posedge CLK or posedge LSR) begin
        if (LSR) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (START) state_d = ST_PRIME;
            ST_PRIME:         if (prime_end) state_d = ST_RUN;
            ST_RUN:           if (run_end) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // cnt counts PRIME cycles, then doubles as the RUN compare index.
    // TX drops to 0 on the last RUN edge so it already reads 0 in DONE.
    always_comb begin
        cnt_d = cnt_q;
        if (start_acc || prime_end) begin
            cnt_d = '0;
        end else if (active) begin
            cnt_d = cnt_q + 1'b1;
        end

        dly_d = start_acc ? '0 : ((dly_q << 1) | LOOP_LAT'(tx_q));
        tx_d  = (active && !run_end) ? lfsr_bit : 1'b0;

        err_d = err_q;
        if (start_acc) begin
            err_d = '0;
        end else if (mismatch && (err_q != '1)) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge LSR) begin
        if (LSR) begin
            cnt_q <= '0;
            dly_q <= '0;
            tx_q  <= 1'b0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            dly_q <= dly_d;
            tx_q  <= tx_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        unique case (state_q)
            ST_PRIME, ST_RUN: BUSY = 1'b1;
            ST_DONE:          DONE = 1'b1;
            default:          ;
        endcase
        PASS = DONE && (err_q == '0);
    end

    assign TX      = tx_q;
    assign ERR_CNT = err_q;

`ifdef ROUTE_CHK_FIRST_ERR_EN
    localparam int IDX_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

    logic             first_vld_q;
    logic             first_vld_d;
    logic [IDX_W-1:0] first_idx_q;
    logic [IDX_W-1:0] first_idx_d;

    always_comb begin
        first_vld_d = first_vld_q;
        first_idx_d = first_idx_q;
        if (start_acc) begin
            first_vld_d = 1'b0;
            first_idx_d = '0;
        end else if (mismatch && !first_vld_q) begin
            first_vld_d = 1'b1;
            first_idx_d = IDX_W'(cnt_q);
        end
    end

    always_ff @(posedge CLK or posedge LSR) begin
        if (LSR) begin
            first_vld_q <= 1'b0;
            first_idx_q <= '0;
        end else begin
            first_vld_q <= first_vld_d;
            first_idx_q <= first_idx_d;
        end
    end

    assign FIRST_ERR_IDX = first_vld_q ? first_idx_q : '1;
`endif

endmodule

// File: tb/tb_route_prbs_checker.sv
// tb_route_prbs_checker: table-driven runs with a scoreboard of expected end-of-run
// results, plus hand sequences for reset mid-run and DONE hold.
`timescale 1ns/1ps
module tb_route_prbs_checker;

    localparam int N_A  = 1024;
    localparam int L_A  = 1;
    localparam int N_B  = 100;
    localparam int L_B  = 3;
    localparam int MODEL_LEN = 1200;

    typedef struct {
        string name;
        bit    use_b;
        int    rx_mode;
        int    inj0;
        int    inj1;
        int    bs0;
        int    bs1;
        int    exp_err;
        bit    exp_pass;
        int    exp_fidx;
    } vec_t;

    typedef struct {
        int done_cyc;
        int err;
        bit pass;
        int fidx;
    } sb_t;

    logic        clk;
    logic        lsr;
    logic        start_a, rx_a, tx_a, busy_a, done_a, pass_a;
    logic [15:0] err_a;
    logic        start_b, rx_b, tx_b, busy_b, done_b, pass_b;
    logic [3:0]  err_b;
    bit          sel;
    logic        tx_cur, busy_cur, done_cur, pass_cur;
    logic [15:0] err_cur;
`ifdef ROUTE_CHK_FIRST_ERR_EN
    logic [9:0]  fidx_a;
    logic [6:0]  fidx_b;
    logic [9:0]  fidx_cur;
`endif

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  prbs [MODEL_LEN];
    sb_t sb_q [$];
    vec_t tab [8];

    route_prbs_checker #(
        .LFSR_W(7), .LOOP_LAT(L_A), .RUN_CYCLES(N_A), .ERR_W(16)
    ) dut_a (
        .CLK(clk), .LSR(lsr), .START(start_a), .TX(tx_a), .RX(rx_a),
        .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .ERR_CNT(err_a)
`ifdef ROUTE_CHK_FIRST_ERR_EN
        , .FIRST_ERR_IDX(fidx_a)
`endif
    );

    route_prbs_checker #(
        .LFSR_W(7), .LOOP_LAT(L_B), .RUN_CYCLES(N_B), .ERR_W(4)
    ) dut_b (
        .CLK(clk), .LSR(lsr), .START(start_b), .TX(tx_b), .RX(rx_b),
        .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .ERR_CNT(err_b)
`ifdef ROUTE_CHK_FIRST_ERR_EN
        , .FIRST_ERR_IDX(fidx_b)
`endif
    );

    assign tx_cur   = sel ? tx_b : tx_a;
    assign busy_cur = sel ? busy_b : busy_a;
    assign done_cur = sel ? done_b : done_a;
    assign pass_cur = sel ? pass_b : pass_a;
    assign err_cur  = sel ? 16'(err_b) : err_a;
`ifdef ROUTE_CHK_FIRST_ERR_EN
    assign fidx_cur = sel ? 10'(fidx_b) : fidx_a;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference sequence from the recurrence a[i] = a[i-6] ^ a[i-7], seed all ones.
    function automatic void build_prbs();
        for (int i = 0; i < MODEL_LEN; i++) begin
            prbs[i] = (i < 7) ? 1'b1 : (prbs[i-6] ^ prbs[i-7]);
        end
    endfunction

    function automatic bit exp_bit(input int k);
        return (k == 0) ? 1'b0 : prbs[k-1];
    endfunction

    function automatic bit tx_model(input int c, input int lat, input int n);
        return (c >= 2 && c <= lat + n) ? prbs[c-2] : 1'b0;
    endfunction

    function automatic vec_t mk(input string nm, input bit use_b, input int mode,
                                input int i0, input int i1, input int bs0, input int bs1);
        vec_t v;
        int   n, sat, cnt, first;
        bit   e, r;
        n     = use_b ? N_B : N_A;
        sat   = use_b ? 15 : 65535;
        cnt   = 0;
        first = -1;
        for (int k = 0; k < n; k++) begin
            e = exp_bit(k);
            case (mode)
                1:       r = 1'b0;
                2:       r = 1'b1;
                3:       r = !e;
                default: r = e;
            endcase
            if (k == i0 || k == i1) r = !r;
            if (r != e) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        v.name     = nm;
        v.use_b    = use_b;
        v.rx_mode  = mode;
        v.inj0     = i0;
        v.inj1     = i1;
        v.bs0      = bs0;
        v.bs1      = bs1;
        v.exp_err  = (cnt > sat) ? sat : cnt;
        v.exp_pass = (cnt == 0);
        v.exp_fidx = (first < 0) ? (use_b ? 127 : 1023) : first;
        return v;
    endfunction

    task automatic checkOutput(input string nm, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic drive(input bit s, input bit r);
        if (sel) begin
            start_b = s;
            rx_b    = r;
        end else begin
            start_a = s;
            rx_a    = r;
        end
    endtask

    // One run: START at cycle 0, RX built from recorded TX per rx_mode, results via scoreboard.
    task automatic applyStimulus(input vec_t v);
        int  lat, n, done_exp, tx_err, busy_cnt, k;
        bit  seen, r;
        bit  txh [2048];
        sb_t got;
        lat      = v.use_b ? L_B : L_A;
        n        = v.use_b ? N_B : N_A;
        done_exp = 1 + lat + n;
        tx_err   = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        sel      = v.use_b;
        $display("[TB] run %s", v.name);
        sb_q.push_back('{done_cyc: done_exp, err: v.exp_err, pass: v.exp_pass, fidx: v.exp_fidx});
        for (int c = 0; c <= done_exp + 8 && !seen; c++) begin
            txh[c] = tx_cur;
            if (tx_cur !== tx_model(c, lat, n)) tx_err++;
            if (c > 0 && done_cur === 1'b1) begin
                seen = 1'b1;
                got  = sb_q.pop_front();
                checkOutput({v.name, ".done_cycle"}, c, got.done_cyc);
                checkOutput({v.name, ".err_cnt"}, err_cur, got.err);
                checkOutput({v.name, ".pass"}, pass_cur, got.pass);
`ifdef ROUTE_CHK_FIRST_ERR_EN
                checkOutput({v.name, ".first_err_idx"}, fidx_cur, got.fidx);
`endif
            end else begin
                busy_cnt += int'(busy_cur);
                k = c - 1 - lat;
                r = (c >= lat) ? txh[c - lat] : 1'b0;
                if (k >= 0 && k < n) begin
                    case (v.rx_mode)
                        1:       r = 1'b0;
                        2:       r = 1'b1;
                        3:       r = !r;
                        default: ;
                    endcase
                    if (k == v.inj0 || k == v.inj1) r = !r;
                end
                drive(c == 0 || c == v.bs0 || c == v.bs1, r);
                @(posedge clk);
                #1;
            end
        end
        drive(1'b0, 1'b0);
        if (!seen) begin
            checkOutput({v.name, ".done_timeout"}, 0, 1);
            void'(sb_q.pop_front());
        end
        checkOutput({v.name, ".busy_cycles"}, busy_cnt, lat + n);
        checkOutput({v.name, ".tx_stream_errors"}, tx_err, 0);
    endtask

    initial begin
        int abort_err;
        lsr = 1'b0; start_a = 1'b0; rx_a = 1'b0; start_b = 1'b0; rx_b = 1'b0; sel = 1'b0;
        build_prbs();
        tab[0] = mk("loop_clean",     1'b0, 0, -1, -1, -1, -1);
        tab[1] = mk("rx_tied0",       1'b0, 1, -1, -1, -1, -1);
        tab[2] = mk("loop_inj37",     1'b0, 0, 37, -1, -1, -1);
        tab[3] = mk("loop_inj_edges", 1'b0, 0, 0, N_A - 1, 5, L_A + N_A);
        tab[4] = mk("rx_tied1",       1'b0, 2, -1, -1, 1, -1);
        tab[5] = mk("loop_restart",   1'b0, 0, -1, -1, -1, -1);
        tab[6] = mk("b_inverted_sat", 1'b1, 3, -1, -1, -1, -1);
        tab[7] = mk("b_loop_inj99",   1'b1, 0, 99, -1, 50, -1);

        #2 lsr = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset.tx_a",   tx_a, 0);
        checkOutput("reset.busy_a", busy_a, 0);
        checkOutput("reset.done_a", done_a, 0);
        checkOutput("reset.pass_a", pass_a, 0);
        checkOutput("reset.err_a",  err_a, 0);
        checkOutput("reset.busy_b", busy_b, 0);
        checkOutput("reset.err_b",  err_b, 0);
`ifdef ROUTE_CHK_FIRST_ERR_EN
        checkOutput("reset.first_err_idx_a", fidx_a, 1023);
`endif
        lsr = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(tab[i]);
        end

        repeat (20) @(posedge clk);
        #1;
        checkOutput("hold.done_b", done_b, 1);
        checkOutput("hold.err_b",  err_b, tab[7].exp_err);

        // Abort a run with RX tied low at RUN index 50, then reset together with START.
        sel = 1'b0;
        start_a = 1'b1;
        rx_a    = 1'b0;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (L_A + 50) @(posedge clk);
        #1;
        abort_err = 0;
        for (int k = 0; k < 50; k++) abort_err += int'(exp_bit(k));
        checkOutput("abort.err_before_reset", err_a, abort_err);
        checkOutput("abort.busy_before_reset", busy_a, 1);
        lsr     = 1'b1;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort.tx",   tx_a, 0);
        checkOutput("abort.busy", busy_a, 0);
        checkOutput("abort.done", done_a, 0);
        checkOutput("abort.pass", pass_a, 0);
        checkOutput("abort.err",  err_a, 0);
        lsr     = 1'b0;
        start_a = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort.idle_after_release", busy_a, 0);
        applyStimulus(tab[0]);

        checkOutput("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
